// File: rtl/cnt_pkg.sv
// Shared definitions for the counter family: direction encodings and the
// terminal-count helper used by every counter variant.
package cnt_pkg;

  // Direction encodings for the mode input.
  localparam logic CNT_UP = 1'b0;
  localparam logic CNT_DN = 1'b1;

  // Highest value a modulo-N counter ever holds.
  function automatic int cnt_max(input int modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Parametrised synchronous modulo-N up/down counter with parallel load,
// count enable, cascade carry-in/carry-out and a registered wrap pulse.
// Optional build macro: CNT_SAT_EN selects saturating behaviour at the
// limits (count still pulses on each attempted step past a limit, co is 0).
module mod_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ci,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] cq,
  output logic             count,
  output logic             co
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(cnt_max(MODULUS));
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  // Reject parameter sets that would let cq escape 0..MODULUS-1.
  if (MODULUS < 2) begin : g_chk_mod_lo
    $error("mod_updown_counter: MODULUS must be at least 2");
  end
  if (64'(MODULUS) > (64'd1 << WIDTH)) begin : g_chk_mod_hi
    $error("mod_updown_counter: MODULUS must not exceed 2**WIDTH");
  end
  if (RST_VAL >= MODULUS || RST_VAL < 0) begin : g_chk_rst
    $error("mod_updown_counter: RST_VAL must lie in 0..MODULUS-1");
  end

  logic [WIDTH-1:0] cq_q, cq_d;
  logic             count_q, count_d;
  logic             step;
  logic             at_limit;

  // Counting advances only when both the local enable and the cascade input agree.
  assign step     = en & ci;
  assign at_limit = (mode == CNT_DN) ? (cq_q == ZERO_V) : (cq_q == MAX_V);

  // Next-state and wrap-pulse logic; load beats stepping, otherwise hold.
  always_comb begin
    cq_d    = cq_q;
    count_d = 1'b0;
    if (load) begin
      // Out-of-range presets clamp to the top value so cq stays legal.
      cq_d = (preset > MAX_V) ? MAX_V : preset;
    end else if (step) begin
      if (at_limit) begin
        count_d = 1'b1;
`ifdef CNT_SAT_EN
        cq_d    = cq_q;
`else
        cq_d    = (mode == CNT_DN) ? MAX_V : ZERO_V;
`endif
      end else begin
        cq_d = (mode == CNT_DN) ? (cq_q - ONE_V) : (cq_q + ONE_V);
      end
    end
  end

  // State register with synchronous active-low reset taking top priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cq_q    <= RST_V;
      count_q <= 1'b0;
    end else begin
      cq_q    <= cq_d;
      count_q <= count_d;
    end
  end

  assign cq    = cq_q;
  assign count = count_q;

  // Carry-out is combinational so the next digit advances on the wrap edge.
`ifdef CNT_SAT_EN
  assign co = 1'b0;
`else
  assign co = rst & step & at_limit;
`endif

endmodule
